// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the I/D-cache memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IC_B0 = 3'd1,
    S_IC_B1 = 3'd2,
    S_DC_RD = 3'd3,
    S_DC_WR = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  // Word address of one half of an aligned two-word I-cache line.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a, input logic beat);
    return {a[ADDR_W-1:1], beat};
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// rtl/mem_arbiter_arb_rr2.sv - 2-way grant selector; MEM_ARB_RR_EN selects round-robin, else D-cache priority
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_ic_i,
  input  logic req_dc_i,
  input  logic advance_i,
  output logic gnt_ic_o,
  output logic gnt_dc_o
);

`ifdef MEM_ARB_RR_EN
  req_id_e last_q, last_d;

  always_comb begin
    gnt_dc_o = req_dc_i && (!req_ic_i || (last_q == REQ_IC));
    gnt_ic_o = req_ic_i && (!req_dc_i || (last_q == REQ_DC));
    last_d   = last_q;
    if (advance_i && gnt_dc_o) last_d = REQ_DC;
    else if (advance_i && gnt_ic_o) last_d = REQ_IC;
  end

  // Reset value marks the I-cache as last served so the D-cache wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= REQ_IC;
    else       last_q <= last_d;
  end
`else
  logic unused_ports;

  assign unused_ports = ^{clk_i, rst_i, advance_i};
  assign gnt_dc_o     = req_dc_i;
  assign gnt_ic_o     = req_ic_i && !req_dc_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I-cache refill / D-cache read-write arbiter onto one memory port
// Optional round-robin tie-break between caches is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_in,
  input  logic              ic_req_in,
  input  logic [ADDR_W-1:0] ic_addr_in,
  output logic              ic_ack_out,
  output logic              ic_rvalid_out,
  output logic [63:0]       ic_rdata_out,
  input  logic              dc_rd_req_in,
  input  logic              dc_wr_req_in,
  input  logic [ADDR_W-1:0] dc_addr_in,
  input  logic [BE_W-1:0]   dc_byte_w_en_in,
  input  logic [DATA_W-1:0] dc_wdata_in,
  output logic              dc_ack_out,
  output logic              dc_rvalid_out,
  output logic [DATA_W-1:0] dc_rdata_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [BE_W-1:0]   mem_be_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic              mem_ready_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              busy_out
);

  state_e              state_q, state_d;
  logic                ic_req_q, ic_req_d;
  logic                dc_rd_q, dc_rd_d;
  logic                dc_wr_q, dc_wr_d;
  logic                flushed_q, flushed_d;
  logic [DATA_W-1:0]   beat0_q, beat0_d;
  logic                ic_ack_q, ic_ack_d;
  logic                ic_rvalid_q, ic_rvalid_d;
  logic [63:0]         ic_rdata_q, ic_rdata_d;
  logic                dc_ack_q, dc_ack_d;
  logic                dc_rvalid_q, dc_rvalid_d;
  logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                in_idle, gnt_ic, gnt_dc, end_beat;

  // Request views are registered; the ack cycle is masked so a held request is not re-granted.
  assign ic_req_d = ic_req_in && !ic_ack_q;
  assign dc_rd_d  = dc_rd_req_in && !dc_ack_q;
  assign dc_wr_d  = dc_wr_req_in && !dc_ack_q;
  assign in_idle  = (state_q == S_IDLE);

  arb_rr2 u_arb (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_ic_i  (in_idle && ic_req_q && !flush_in),
    .req_dc_i  (in_idle && (dc_rd_q || dc_wr_q)),
    .advance_i (in_idle),
    .gnt_ic_o  (gnt_ic),
    .gnt_dc_o  (gnt_dc)
  );

  always_comb begin
    state_d     = state_q;
    flushed_d   = flushed_q;
    beat0_d     = beat0_q;
    ic_ack_d    = 1'b0;
    dc_ack_d    = 1'b0;
    ic_rvalid_d = 1'b0;
    dc_rvalid_d = 1'b0;
    ic_rdata_d  = '0;
    dc_rdata_d  = '0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    end_beat    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (gnt_dc) begin
          dc_ack_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_addr_d  = dc_addr_in;
          // A simultaneous read is dropped in favour of the write.
          if (dc_wr_q) begin
            state_d     = S_DC_WR;
            mem_we_d    = 1'b1;
            mem_be_d    = dc_byte_w_en_in;
            mem_wdata_d = dc_wdata_in;
          end else begin
            state_d     = S_DC_RD;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_wdata_d = '0;
          end
        end else if (gnt_ic) begin
          state_d     = S_IC_B0;
          ic_ack_d    = 1'b1;
          flushed_d   = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = beat_addr(ic_addr_in, 1'b0);
          mem_be_d    = '1;
          mem_wdata_d = '0;
        end
      end
      S_IC_B0: begin
        flushed_d = flushed_q || flush_in;
        if (mem_ready_in) begin
          state_d    = S_IC_B1;
          beat0_d    = mem_rdata_in;
          mem_addr_d = beat_addr(mem_addr_q, 1'b1);
        end
      end
      S_IC_B1: begin
        flushed_d = flushed_q || flush_in;
        if (mem_ready_in) begin
          state_d     = S_RESP;
          ic_rvalid_d = !(flushed_q || flush_in);
          ic_rdata_d  = {mem_rdata_in, beat0_q};
          end_beat    = 1'b1;
        end
      end
      S_DC_RD: begin
        if (mem_ready_in) begin
          state_d     = S_RESP;
          dc_rvalid_d = 1'b1;
          dc_rdata_d  = mem_rdata_in;
          end_beat    = 1'b1;
        end
      end
      S_DC_WR: begin
        if (mem_ready_in) begin
          state_d  = S_IDLE;
          end_beat = 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: begin
        state_d  = S_IDLE;
        end_beat = 1'b1;
      end
    endcase

    if (end_beat) begin
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_be_d    = '0;
      mem_wdata_d = '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ic_req_q    <= 1'b0;
      dc_rd_q     <= 1'b0;
      dc_wr_q     <= 1'b0;
      flushed_q   <= 1'b0;
      beat0_q     <= '0;
      ic_ack_q    <= 1'b0;
      ic_rvalid_q <= 1'b0;
      ic_rdata_q  <= '0;
      dc_ack_q    <= 1'b0;
      dc_rvalid_q <= 1'b0;
      dc_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ic_req_q    <= ic_req_d;
      dc_rd_q     <= dc_rd_d;
      dc_wr_q     <= dc_wr_d;
      flushed_q   <= flushed_d;
      beat0_q     <= beat0_d;
      ic_ack_q    <= ic_ack_d;
      ic_rvalid_q <= ic_rvalid_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_ack_q    <= dc_ack_d;
      dc_rvalid_q <= dc_rvalid_d;
      dc_rdata_q  <= dc_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // A flush arriving during the response cycle itself still kills the line.
  assign ic_rvalid_out = ic_rvalid_q && !flush_in;
  assign ic_ack_out    = ic_ack_q;
  assign ic_rdata_out  = ic_rdata_q;
  assign dc_ack_out    = dc_ack_q;
  assign dc_rvalid_out = dc_rvalid_q;
  assign dc_rdata_out  = dc_rdata_q;
  assign mem_req_out   = mem_req_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_be_out    = mem_be_q;
  assign mem_wdata_out = mem_wdata_q;
  assign busy_out      = busy_q;

endmodule
